// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: merges ALU results and FIFO-buffered LSU results onto the single
// register-file write port. Optional starvation guard enabled by REGFILE_WB_STARVE_GUARD_EN.
module regfile_wb_arbiter #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid_i,
  input  logic [4:0]  alu_rd_i,
  input  logic [31:0] alu_data_i,
  output logic        alu_hold_o,
  input  logic        lsu_valid_i,
  output logic        lsu_ready_o,
  input  logic [4:0]  lsu_rd_i,
  input  logic [31:0] lsu_data_i,
  output logic        we_o,
  output logic [4:0]  rd_o,
  output logic [31:0] wr_rd_o,
  output logic [31:0] pend_mask_o,
  output logic        ovf_err_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two, at least 2");
  end
  if (STARVE_MAX < 1 || STARVE_MAX > 255) begin : g_bad_starve
    $error("STARVE_MAX must be in 1..255");
  end

  logic [4:0]    mem_rd_q   [DEPTH];
  logic [31:0]   mem_data_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          we_q, we_d;
  logic [4:0]    rd_q, rd_d;
  logic [31:0]   wr_rd_q, wr_rd_d;
  logic          empty, full, push, pop, alu_sel;
  logic [31:0]   pend_mask;

  assign empty       = (count_q == '0);
  assign full        = (count_q == CW'(DEPTH));
  assign lsu_ready_o = !full;
  assign push        = lsu_valid_i && !full;

  // A held ALU is never selected; its result (if any) is dropped.
  assign alu_sel = alu_valid_i && !alu_hold_o;
  assign pop     = !empty && (alu_hold_o || !alu_valid_i);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    we_d     = 1'b0;
    rd_d     = rd_q;
    wr_rd_d  = wr_rd_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
    if (pop) begin
      we_d    = (mem_rd_q[rd_ptr_q] != 5'd0);
      rd_d    = mem_rd_q[rd_ptr_q];
      wr_rd_d = mem_data_q[rd_ptr_q];
    end else if (alu_sel) begin
      we_d    = (alu_rd_i != 5'd0);
      rd_d    = alu_rd_i;
      wr_rd_d = alu_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      we_q     <= 1'b0;
      rd_q     <= '0;
      wr_rd_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      we_q     <= we_d;
      rd_q     <= rd_d;
      wr_rd_q  <= wr_rd_d;
    end
  end

  // Storage needs no reset: only entries covered by count_q are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_rd_q[wr_ptr_q]   <= lsu_rd_i;
      mem_data_q[wr_ptr_q] <= lsu_data_i;
    end
  end

  always_comb begin
    pend_mask = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count_q) begin
        pend_mask = pend_mask | (32'd1 << mem_rd_q[rd_ptr_q + AW'(i)]);
      end
    end
  end

  assign pend_mask_o = {pend_mask[31:1], 1'b0};
  assign we_o        = we_q;
  assign rd_o        = rd_q;
  assign wr_rd_o     = wr_rd_q;

`ifdef REGFILE_WB_STARVE_GUARD_EN
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       ovf_err_q, ovf_err_d;

  assign alu_hold_o = (wait_cnt_q == 8'(STARVE_MAX)) && !empty;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    ovf_err_d  = ovf_err_q;
    if (pop || empty) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != 8'(STARVE_MAX)) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
    if (alu_valid_i && alu_hold_o) begin
      ovf_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
      ovf_err_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      ovf_err_q  <= ovf_err_d;
    end
  end

  assign ovf_err_o = ovf_err_q;
`else
  assign alu_hold_o = 1'b0;
  assign ovf_err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: queue-based reference model compared every
// cycle, plus directed literal expectations. Honours REGFILE_WB_STARVE_GUARD_EN.
module tb_regfile_wb_arbiter;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned SMAX  = 3;

  logic        clk;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_hold;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        we;
  logic [4:0]  rd;
  logic [31:0] wr_rd;
  logic [31:0] pend_mask;
  logic        ovf_err;

  regfile_wb_arbiter #(
    .DEPTH      (DEPTH),
    .STARVE_MAX (SMAX)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .alu_valid_i (alu_valid),
    .alu_rd_i    (alu_rd),
    .alu_data_i  (alu_data),
    .alu_hold_o  (alu_hold),
    .lsu_valid_i (lsu_valid),
    .lsu_ready_o (lsu_ready),
    .lsu_rd_i    (lsu_rd),
    .lsu_data_i  (lsu_data),
    .we_o        (we),
    .rd_o        (rd),
    .wr_rd_o     (wr_rd),
    .pend_mask_o (pend_mask),
    .ovf_err_o   (ovf_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  int          m_wait;
  bit          m_we;
  bit          m_ovf;
  logic [4:0]  m_rd;
  logic [31:0] m_wr;

  function automatic bit m_hold();
`ifdef REGFILE_WB_STARVE_GUARD_EN
    return (m_wait == SMAX) && (q.size() > 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] m_pend();
    logic [31:0] m;
    m = '0;
    foreach (q[i]) m = m | (32'd1 << q[i].rd);
    m[0] = 1'b0;
    return m;
  endfunction

  initial begin
    bit   hold, was_empty, can_push, popped, have;
    ent_t sel;
    q.delete();
    m_wait = 0; m_we = 0; m_ovf = 0; m_rd = '0; m_wr = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        q.delete();
        m_wait = 0; m_we = 0; m_ovf = 0; m_rd = '0; m_wr = '0;
      end else begin
        hold      = m_hold();
        was_empty = (q.size() == 0);
        can_push  = (q.size() < DEPTH);
        popped    = 0;
        have      = 0;
        if (hold) begin
          sel = q.pop_front(); popped = 1; have = 1;
        end else if (alu_valid) begin
          sel = '{rd: alu_rd, data: alu_data}; have = 1;
        end else if (!was_empty) begin
          sel = q.pop_front(); popped = 1; have = 1;
        end
        if (alu_valid && hold) m_ovf = 1;
        if (popped || was_empty) m_wait = 0;
        else if (m_wait < SMAX) m_wait++;
        m_we = have && (sel.rd != 0);
        if (have) begin
          m_rd = sel.rd;
          m_wr = sel.data;
        end
        if (lsu_valid && can_push) q.push_back('{rd: lsu_rd, data: lsu_data});
      end
    end
  end

  // ---------------- per-cycle comparison ----------------
  initial begin
    forever begin
      @(negedge clk);
      chk("we", we, m_we);
      chk("rd", rd, m_rd);
      chk("wr_rd", wr_rd, m_wr);
      chk("lsu_ready", lsu_ready, q.size() < DEPTH);
      chk("alu_hold", alu_hold, m_hold());
      chk("pend_mask", pend_mask, m_pend());
      chk("ovf_err", ovf_err, m_ovf);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    alu_valid = 0; alu_rd = '0; alu_data = '0;
    lsu_valid = 0; lsu_rd = '0; lsu_data = '0;
    #1 rst_n = 1'b0;
    repeat (2) cyc();
    chk("rst_we", we, 0);
    chk("rst_wr_rd", wr_rd, 0);
    chk("rst_lsu_ready", lsu_ready, 1);
    chk("rst_pend", pend_mask, 0);
    rst_n = 1'b1;

    // ALU only
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    cyc();
    chk("alu_we", we, 1);
    chk("alu_rd", rd, 5);
    chk("alu_data", wr_rd, 32'hDEADBEEF);
    alu_rd = 0; alu_data = 32'h1;
    cyc();
    chk("alu_x0_we", we, 0);
    alu_valid = 0;

    // LSU only
    lsu_valid = 1; lsu_rd = 7; lsu_data = 32'h12345678;
    cyc();
    lsu_valid = 0;
    chk("lsu_pend", pend_mask, 32'h80);
    chk("lsu_no_bypass", we, 0);
    cyc();
    chk("lsu_we", we, 1);
    chk("lsu_rd", rd, 7);
    chk("lsu_data", wr_rd, 32'h12345678);
    chk("lsu_pend_clr", pend_mask, 0);
    cyc();

    // Fill with the ALU busy, then drain in order
    alu_valid = 1; alu_rd = 9;
    for (int i = 0; i < 4; i++) begin
      alu_data = 32'h900 + i;
      lsu_valid = 1; lsu_rd = 5'(i + 1); lsu_data = 32'h100 + i;
      cyc();
    end
    lsu_valid = 0; alu_valid = 0;
    chk("fill_ready", lsu_ready, 0);
    chk("fill_pend", pend_mask, 32'h1E);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("drain_we", we, 1);
      chk("drain_rd", rd, i + 1);
      chk("drain_data", wr_rd, 32'h100 + i);
    end
    cyc();

    // Starvation: one entry behind a continuously busy ALU
    alu_valid = 1; alu_rd = 11; alu_data = 32'h1100;
    lsu_valid = 1; lsu_rd = 10; lsu_data = 32'hA5A50000;
    cyc();
    lsu_valid = 0;
    cyc();
    cyc();
    chk("starve_hold_early", alu_hold, 0);
    cyc();
    chk("starve_pend", pend_mask, 32'h400);
`ifdef REGFILE_WB_STARVE_GUARD_EN
    chk("starve_hold", alu_hold, 1);
`else
    chk("starve_hold_off", alu_hold, 0);
`endif
    alu_valid = 0;
    cyc();
    chk("starve_we", we, 1);
    chk("starve_rd", rd, 10);
    chk("starve_hold_clr", alu_hold, 0);
    cyc();

    // Protocol violation: ALU asserted while held
    alu_valid = 1; alu_rd = 12; alu_data = 32'h0BAD0BAD;
    lsu_valid = 1; lsu_rd = 13; lsu_data = 32'h13;
    cyc();
    lsu_valid = 0;
    repeat (3) cyc();
    alu_data = 32'hDEAD0001;
    cyc();
`ifdef REGFILE_WB_STARVE_GUARD_EN
    chk("viol_rd", rd, 13);
    chk("viol_data", wr_rd, 32'h13);
    chk("viol_ovf", ovf_err, 1);
`else
    chk("viol_off_data", wr_rd, 32'hDEAD0001);
    chk("viol_off_ovf", ovf_err, 0);
`endif
    alu_valid = 0;
    repeat (3) cyc();

    // Async reset with three queued entries
    alu_valid = 1; alu_rd = 20; alu_data = 32'h2000;
    for (int i = 0; i < 3; i++) begin
      lsu_valid = 1; lsu_rd = 5'(21 + i); lsu_data = 32'h2100 + i;
      cyc();
    end
    lsu_valid = 0;
    chk("q3_pend", pend_mask, 32'h00E00000);
`ifdef REGFILE_WB_STARVE_GUARD_EN
    chk("ovf_sticky", ovf_err, 1);
`endif
    #2 rst_n = 1'b0;
    alu_valid = 0;
    #1;
    chk("arst_we", we, 0);
    chk("arst_rd", rd, 0);
    chk("arst_wr_rd", wr_rd, 0);
    chk("arst_pend", pend_mask, 0);
    chk("arst_ready", lsu_ready, 1);
    chk("arst_ovf", ovf_err, 0);
    cyc();
    rst_n = 1'b1;
    repeat (3) cyc();
    chk("post_rst_we", we, 0);
    chk("post_rst_pend", pend_mask, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
